// File: rtl/ddr_arb.sv
// ddr_arb: two-requester arbiter in front of a single downstream DDR command port.
// A winning command is latched and held on ddr_* until the controller accepts it.
// Outstanding reads are tracked in a small tag FIFO so that returned read data
// is steered back to the requester that issued it, in downstream issue order.
// Build option: define DDR_ARB_RR_EN for round-robin arbitration between m0 and
// m1; when it is undefined, m0 has fixed priority whenever it is eligible.
module ddr_arb #(
  parameter int AW        = 8,
  parameter int DW        = 64,
  parameter int TAG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  // requester 0
  input  logic          m0_req,
  output logic          m0_ack,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_rd_en,
  // requester 1
  input  logic          m1_req,
  output logic          m1_ack,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_rd_en,
  // shared read data
  output logic [DW-1:0] m_rdata,
  // downstream controller
  output logic          ddr_req,
  input  logic          ddr_ack,
  output logic          ddr_write,
  output logic [AW-1:0] ddr_addr,
  output logic [DW-1:0] ddr_wdata,
  input  logic          ddr_rd_en,
  input  logic [DW-1:0] ddr_rdata,
  output logic          err_unexp
);

  // Pointer width indexes the tag ring; the count needs one extra value (full).
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  logic                 grant;      // 0 = m0 owns the latched command, 1 = m1

  logic [TAG_DEPTH-1:0] tag_mem;    // requester ID of each outstanding read
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        tag_cnt;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 head;

  logic                 elig0;
  logic                 elig1;
  logic                 pick_valid;
  logic                 pick_id;

  logic                 xfer;
  logic                 push;
  logic                 pop;

  assign tag_full  = (tag_cnt == CW'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign head      = tag_mem[rd_ptr];

  // A read may only be issued while a tag slot is free; writes never need one.
  assign elig0 = m0_req & (m0_write | ~tag_full);
  assign elig1 = m1_req & (m1_write | ~tag_full);

`ifdef DDR_ARB_RR_EN
  logic rr_pref;                    // port that gets first pick next arbitration

  // Hand first pick to the port that did not win the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_pref <= 1'b0;
    end else if ((state == IDLE) && pick_valid) begin
      rr_pref <= ~pick_id;
    end
  end

  // Preferred port wins if eligible, otherwise the other port if eligible.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 1'b0;
    if (rr_pref) begin
      if (elig1) begin
        pick_valid = 1'b1;
        pick_id    = 1'b1;
      end else if (elig0) begin
        pick_valid = 1'b1;
        pick_id    = 1'b0;
      end
    end else begin
      if (elig0) begin
        pick_valid = 1'b1;
        pick_id    = 1'b0;
      end else if (elig1) begin
        pick_valid = 1'b1;
        pick_id    = 1'b1;
      end
    end
  end
`else
  // m0 wins whenever eligible; m1 only gets the port when m0 cannot use it.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 1'b0;
    if (elig0) begin
      pick_valid = 1'b1;
      pick_id    = 1'b0;
    end else if (elig1) begin
      pick_valid = 1'b1;
      pick_id    = 1'b1;
    end
  end
`endif

  // Downstream transfer happens on a BUSY cycle where the controller accepts.
  assign xfer = (state == BUSY) & ddr_ack;
  assign push = xfer & ~ddr_write;
  assign pop  = ddr_rd_en & ~tag_empty;

  // Command FSM: latch the winner in IDLE, hold it stable in BUSY until ddr_ack.
  // Going back to IDLE after every transfer gives at least one idle cycle
  // between downstream commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      ddr_req   <= 1'b0;
      ddr_write <= 1'b0;
      ddr_addr  <= '0;
      ddr_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= BUSY;
            grant   <= pick_id;
            ddr_req <= 1'b1;
            if (pick_id) begin
              ddr_write <= m1_write;
              ddr_addr  <= m1_addr;
              ddr_wdata <= m1_wdata;
            end else begin
              ddr_write <= m0_write;
              ddr_addr  <= m0_addr;
              ddr_wdata <= m0_wdata;
            end
          end
        end
        BUSY: begin
          if (ddr_ack) begin
            state   <= IDLE;
            ddr_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ddr_req <= 1'b0;
        end
      endcase
    end
  end

  // Tag ring: record the issuer of each accepted read, release on each return.
  // A simultaneous push and pop moves both pointers and leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // A return with nothing outstanding is a protocol error; remember it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_unexp <= 1'b0;
    end else if (ddr_rd_en && tag_empty) begin
      err_unexp <= 1'b1;
    end
  end

  // Acks and read-data enables are gated by rst so nothing leaks out during reset.
  assign m0_ack   = ~rst & xfer & ~grant;
  assign m1_ack   = ~rst & xfer &  grant;
  assign m0_rd_en = ~rst & pop  & ~head;
  assign m1_rd_en = ~rst & pop  &  head;
  assign m_rdata  = ddr_rdata;

endmodule
